ysyx_23060077_ex_alu_arb: RTL

//  Shares the single EX-stage ALU between two requesters: port 0 = EX pipeline, port 1 = multi-cycle sequencer (CSR/AMO).
//  - Round-robin arbitration into one registered issue slot.
//  - Drives the ALU combinational inputs and captures the ALU result into a per-requester response buffer.
//  - valid/ready handshake on both sides; pipeline flush on port 0.

---
 rtl/ysyx_23060077_ex_alu_arb.sv | 109 ++++++++++
 1 files changed

// File: rtl/ysyx_23060077_ex_alu_arb.sv
// Shares the EX-stage ALU between the pipeline (port 0) and the CSR/AMO sequencer (port 1).
// Round-robin grant into one issue slot, one result buffer per requester.
module ysyx_23060077_ex_alu_arb #(
   parameter int DATA_WIDTH = 32,
   parameter int OPT_WIDTH  = 4
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [1:0]                  req_valid,
   output logic [1:0]                  req_ready,
   input  logic [1:0][OPT_WIDTH-1:0]   req_opt,
   input  logic [1:0][DATA_WIDTH-1:0]  req_a,
   input  logic [1:0][DATA_WIDTH-1:0]  req_b,
   output logic [1:0]                  rsp_valid,
   input  logic [1:0]                  rsp_ready,
   output logic [1:0][DATA_WIDTH-1:0]  rsp_data,
   input  logic                        flush0,
   output logic [OPT_WIDTH-1:0]        alu_opt,
   output logic [DATA_WIDTH-1:0]       alu_a_data,
   output logic [DATA_WIDTH-1:0]       alu_b_data,
   input  logic [DATA_WIDTH-1:0]       alu_out_data,
   output logic                        busy
);

   logic                        iss_vld;
   logic                        iss_id;
   logic [OPT_WIDTH-1:0]        iss_opt;
   logic [DATA_WIDTH-1:0]       iss_a;
   logic [DATA_WIDTH-1:0]       iss_b;
   logic [1:0]                  rsp_vld;
   logic [1:0][DATA_WIDTH-1:0]  rsp_buf;
   logic                        prio;

   logic                        kill0;
   logic                        adv;
   logic                        fr;
   logic                        c0;
   logic                        c1;
   logic                        win;
   logic                        acc;

   // Slot advance, kill on flush and round-robin grant selection
   always_comb begin
      kill0     = flush0 & iss_vld & ~iss_id;
      adv       = iss_vld & ~kill0 &
                  (~rsp_vld[iss_id] | rsp_ready[iss_id]);
      fr        = ~iss_vld | adv | kill0;
      c0        = req_valid[0] & ~flush0;
      c1        = req_valid[1];
      win       = (c0 & c1) ? prio : c1;
      acc       = fr & (c0 | c1) & ~reset;
      req_ready = {acc & win, acc & ~win};
   end

   // Issue register and round-robin pointer
   always_ff @(posedge clock) begin
      if (reset) begin
         iss_vld <= 1'b0;
         iss_id  <= 1'b0;
         iss_opt <= '0;
         iss_a   <= '0;
         iss_b   <= '0;
         prio    <= 1'b0;
      end else if (acc) begin
         iss_vld <= 1'b1;
         iss_id  <= win;
         iss_opt <= req_opt[win];
         iss_a   <= req_a[win];
         iss_b   <= req_b[win];
         prio    <= ~win;
      end else if (adv | kill0) begin
         iss_vld <= 1'b0;
      end
   end

   // Port 0 response buffer; a flush drops whatever it holds
   always_ff @(posedge clock) begin
      if (reset) begin
         rsp_vld[0] <= 1'b0;
         rsp_buf[0] <= '0;
      end else if (adv & ~iss_id) begin
         rsp_vld[0] <= 1'b1;
         rsp_buf[0] <= alu_out_data;
      end else if (rsp_ready[0] | flush0) begin
         rsp_vld[0] <= 1'b0;
      end
   end

   // Port 1 response buffer
   always_ff @(posedge clock) begin
      if (reset) begin
         rsp_vld[1] <= 1'b0;
         rsp_buf[1] <= '0;
      end else if (adv & iss_id) begin
         rsp_vld[1] <= 1'b1;
         rsp_buf[1] <= alu_out_data;
      end else if (rsp_ready[1]) begin
         rsp_vld[1] <= 1'b0;
      end
   end

   assign rsp_valid  = rsp_vld;
   assign rsp_data   = rsp_buf;
   assign alu_opt    = iss_opt;
   assign alu_a_data = iss_a;
   assign alu_b_data = iss_b;
   assign busy       = iss_vld | rsp_vld[0] | rsp_vld[1];

endmodule
